// File: rtl/icode_count_ctrl.sv
// Instruction-code counter control: clears the count table, arbitrates two requesters
// onto a 1-cycle-latency issue stream, and on request drains the datapath and reads the table out.
module icode_count_ctrl #(
  parameter int ICODESIZE    = 4,
  parameter int COUNTBITS    = 4,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                 clock_i,
  input  logic                 reset_ni,
  input  logic                 req0_valid_i,
  input  logic [ICODESIZE-1:0] req0_icode_i,
  output logic                 req0_ready_o,
  input  logic                 req1_valid_i,
  input  logic [ICODESIZE-1:0] req1_icode_i,
  output logic                 req1_ready_o,
  input  logic                 dump_req_i,
  output logic                 busy_o,
  output logic                 iss_valid_o,
  output logic [ICODESIZE-1:0] iss_icode_o,
  output logic [ICODESIZE-1:0] mem_addr_o,
  output logic                 mem_we_o,
  output logic [COUNTBITS-1:0] mem_wdata_o,
  input  logic [COUNTBITS-1:0] mem_rdata_i,
  output logic                 dump_valid_o,
  output logic [ICODESIZE-1:0] dump_addr_o,
  output logic [COUNTBITS-1:0] dump_data_o,
  output logic                 dump_done_o
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0]       DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);
  localparam logic [ICODESIZE-1:0] ADDR_LAST  = '1;

  typedef enum logic [1:0] {
    CLEAR,
    RUN,
    DRAIN,
    DUMP
  } state_e;

  state_e               state_q;
  logic [ICODESIZE-1:0] addr_q;
  logic [ICODESIZE-1:0] addr_d;
  logic [DCW-1:0]       drain_q;
  logic                 ptr_q;
  logic                 iss_valid_q;
  logic [ICODESIZE-1:0] iss_icode_q;
  logic                 dump_valid_q;
  logic [ICODESIZE-1:0] dump_addr_q;
  logic                 dump_done_q;
  logic                 arb_en;
  logic                 gnt0;
  logic                 gnt1;

  // ptr_q == 0 points at req0; a lone requester wins regardless of the pointer.
  assign arb_en = (state_q == RUN) && !dump_req_i;
  assign gnt0   = arb_en && req0_valid_i && (!req1_valid_i || !ptr_q);
  assign gnt1   = arb_en && req1_valid_i && (!req0_valid_i ||  ptr_q);
  assign addr_d = addr_q + 1'b1;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= CLEAR;
      addr_q       <= '0;
      drain_q      <= '0;
      ptr_q        <= 1'b0;
      iss_valid_q  <= 1'b0;
      iss_icode_q  <= '0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_done_q  <= 1'b0;
    end else begin
      iss_valid_q  <= gnt0 | gnt1;
      iss_icode_q  <= gnt0 ? req0_icode_i : (gnt1 ? req1_icode_i : '0);
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_done_q  <= 1'b0;
      if (gnt0) begin
        ptr_q <= 1'b1;
      end else if (gnt1) begin
        ptr_q <= 1'b0;
      end

      case (state_q)
        CLEAR: begin
          addr_q <= addr_d;
          if (addr_q == ADDR_LAST) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (dump_req_i) begin
            state_q <= DRAIN;
            drain_q <= '0;
          end
        end
        DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_q <= DUMP;
            addr_q  <= '0;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        DUMP: begin
          // The cycle after the last address only presents the final beat.
          if (dump_done_q) begin
            state_q <= RUN;
          end else begin
            dump_valid_q <= 1'b1;
            dump_addr_q  <= addr_q;
            dump_done_q  <= (addr_q == ADDR_LAST);
            addr_q       <= addr_d;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;
  assign busy_o       = (state_q != RUN);
  assign iss_valid_o  = iss_valid_q;
  assign iss_icode_o  = iss_icode_q;
  assign mem_addr_o   = addr_q;
  assign mem_we_o     = (state_q == CLEAR);
  assign mem_wdata_o  = '0;
  // Table read data returns one cycle after the address, aligned with the registered beat.
  assign dump_valid_o = dump_valid_q;
  assign dump_addr_o  = dump_addr_q;
  assign dump_data_o  = dump_valid_q ? mem_rdata_i : '0;
  assign dump_done_o  = dump_done_q;

endmodule

// File: tb/tb_icode_count_ctrl.sv
// Bench for icode_count_ctrl: vector table, hand sequences and random traffic against a timeline model.
module tb_icode_count_ctrl;
  localparam int IW = 4;
  localparam int CW = 4;
  localparam int DR = 4;
  localparam int N  = 1 << IW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          v0 = 1'b0, v1 = 1'b0, dreq = 1'b0;
  logic [IW-1:0] ic0 = '0, ic1 = '0;
  logic          r0, r1, busy, iss_valid, mem_we, dump_valid, dump_done;
  logic [IW-1:0] iss_icode, mem_addr, dump_addr;
  logic [CW-1:0] mem_wdata, mem_rdata, dump_data;

  always #5 clk = ~clk;

  icode_count_ctrl #(.ICODESIZE(IW), .COUNTBITS(CW), .DRAIN_CYCLES(DR)) dut (
    .clock_i(clk), .reset_ni(rst_n),
    .req0_valid_i(v0), .req0_icode_i(ic0), .req0_ready_o(r0),
    .req1_valid_i(v1), .req1_icode_i(ic1), .req1_ready_o(r1),
    .dump_req_i(dreq), .busy_o(busy),
    .iss_valid_o(iss_valid), .iss_icode_o(iss_icode),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .dump_valid_o(dump_valid), .dump_addr_o(dump_addr), .dump_data_o(dump_data), .dump_done_o(dump_done)
  );

  // Count table plus the external counter datapath that increments on each issued icode.
  logic [CW-1:0] mem [N];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (iss_valid) mem[iss_icode] <= mem[iss_icode] + 1'b1;
    mem_rdata <= mem[mem_addr];
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: arbitration turn, dump timeline offset, pending issue, expected counts.
  bit            turn;
  int            dump_t;
  bit            pend_v;
  logic [IW-1:0] pend_ic;
  int            ref_cnt [N];
  logic          s_r0, s_r1, s_dv, s_done;
  logic [IW-1:0] s_daddr;
  logic [CW-1:0] s_ddata;

  task automatic model_reset();
    turn = 1'b0; dump_t = -1; pend_v = 1'b0; pend_ic = '0;
    for (int i = 0; i < N; i++) ref_cnt[i] = 0;
  endtask

  task automatic cycle(input bit a0, input bit a1, input logic [IW-1:0] i0,
                       input logic [IW-1:0] i1, input bit d);
    bit g0, g1;
    int dd;
    v0 = a0; v1 = a1; ic0 = i0; ic1 = i1; dreq = d;
    @(negedge clk);
    g0 = 1'b0; g1 = 1'b0;
    if (dump_t < 0) begin
      if (d) dump_t = 0;
      else if (a0 && a1) begin
        if (turn) g1 = 1'b1; else g0 = 1'b1;
      end else begin
        g0 = a0; g1 = a1;
      end
    end
    dd = dump_t;
    s_r0 = r0; s_r1 = r1; s_dv = dump_valid; s_done = dump_done;
    s_daddr = dump_addr; s_ddata = dump_data;
    chk("req0_ready", int'(r0), int'(g0));
    chk("req1_ready", int'(r1), int'(g1));
    chk("iss_valid", int'(iss_valid), int'(pend_v));
    chk("iss_icode", int'(iss_icode), pend_v ? int'(pend_ic) : 0);
    chk("busy", int'(busy), int'(dd >= 1));
    chk("mem_we", int'(mem_we), 0);
    chk("mem_wdata", int'(mem_wdata), 0);
    chk("dump_valid", int'(dump_valid), int'(dd >= DR + 2));
    chk("dump_done", int'(dump_done), int'(dd == DR + N + 1));
    if (dd >= DR + 2) begin
      chk("dump_addr", int'(dump_addr), dd - DR - 2);
      chk("dump_data", int'(dump_data), ref_cnt[dd - DR - 2]);
    end
    if (dd >= DR + 1 && dd <= DR + N) chk("dump_mem_addr", int'(mem_addr), dd - DR - 1);
    if (g0 || g1) begin
      pend_v = 1'b1;
      pend_ic = g0 ? i0 : i1;
      ref_cnt[pend_ic] = (ref_cnt[pend_ic] + 1) % (1 << CW);
      turn = g0;
    end else begin
      pend_v = 1'b0; pend_ic = '0;
    end
    if (dump_t >= 0) begin
      dump_t++;
      if (dump_t > DR + N + 1) dump_t = -1;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_iss_valid"}, int'(iss_valid), 0);
    chk({tag, "_iss_icode"}, int'(iss_icode), 0);
    chk({tag, "_dump_valid"}, int'(dump_valid), 0);
    chk({tag, "_dump_addr"}, int'(dump_addr), 0);
    chk({tag, "_dump_data"}, int'(dump_data), 0);
    chk({tag, "_dump_done"}, int'(dump_done), 0);
    chk({tag, "_busy"}, int'(busy), 1);
    chk({tag, "_req0_ready"}, int'(r0), 0);
    chk({tag, "_req1_ready"}, int'(r1), 0);
    chk({tag, "_mem_addr"}, int'(mem_addr), 0);
  endtask

  task automatic release_and_clear();
    @(posedge clk); #1;
    rst_n = 1'b1; v0 = 1'b1; v1 = 1'b1; ic0 = 4'd3; ic1 = 4'd7;
    for (int c = 0; c < N; c++) begin
      dreq = (c >= 4 && c <= 6);
      @(negedge clk);
      chk("clr_we", int'(mem_we), 1);
      chk("clr_addr", int'(mem_addr), c);
      chk("clr_wdata", int'(mem_wdata), 0);
      chk("clr_busy", int'(busy), 1);
      chk("clr_ready", int'(r0 | r1), 0);
      @(posedge clk); #1;
    end
    dreq = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit v0; bit v1; logic [IW-1:0] i0; logic [IW-1:0] i1; bit r0; bit r1;
  } vec_t;
  vec_t tbl [13];

  initial begin
    int beats, dones;
    bit rv0, rv1;
    logic [IW-1:0] ri0, ri1;

    tbl[0]  = '{1'b1, 1'b1, 4'd3, 4'd7, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'd3, 4'd7, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 4'd3, 4'd7, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 4'd3, 4'd7, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 4'd3, 4'd0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 4'd0, 4'd9, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 4'd0, 4'd9, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 4'd0, 4'd9, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 4'd5, 4'd2, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 4'd5, 4'd2, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 4'd5, 4'd0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};

    model_reset();
    v0 = 1'b1; v1 = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset_vals("por");
    release_and_clear();

    foreach (tbl[i]) begin
      cycle(tbl[i].v0, tbl[i].v1, tbl[i].i0, tbl[i].i1, 1'b0);
      chk("tbl_req0_ready", int'(s_r0), int'(tbl[i].r0));
      chk("tbl_req1_ready", int'(s_r1), int'(tbl[i].r1));
    end

    // Dump pulse with both requesters waiting: no grant, drain, 16 beats, then RUN.
    cycle(1'b1, 1'b1, 4'd3, 4'd7, 1'b1);
    chk("dump_cycle_no_ready", int'(s_r0 | s_r1), 0);
    beats = 0; dones = 0;
    for (int k = 1; k <= DR + N + 1; k++) begin
      cycle(1'b1, 1'b1, 4'd3, 4'd7, 1'b0);
      if (s_dv) beats++;
      if (s_done) begin
        dones++;
        chk("done_on_last_addr", int'(s_daddr), N - 1);
      end
    end
    chk("dump_beats", beats, N);
    chk("dump_done_pulses", dones, 1);
    cycle(1'b1, 1'b1, 4'd3, 4'd7, 1'b0);
    chk("run_after_dump_r1", int'(s_r1), 1);

    // Random traffic; requesters hold valid/icode until accepted.
    rv0 = 1'b0; rv1 = 1'b0; ri0 = '0; ri1 = '0;
    for (int k = 0; k < 600; k++) begin
      if (!rv0 || s_r0) begin rv0 = ($urandom_range(0, 3) != 0); ri0 = IW'($urandom_range(0, N - 1)); end
      if (!rv1 || s_r1) begin rv1 = ($urandom_range(0, 3) != 0); ri1 = IW'($urandom_range(0, N - 1)); end
      cycle(rv0, rv1, ri0, ri1, $urandom_range(0, 49) == 0);
    end
    for (int k = 0; k < 40 && dump_t >= 0; k++) cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    chk("run_before_abort", int'(busy), 0);

    // Reset asserted while the readout is at address 8.
    cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    for (int k = 1; k <= DR + 8; k++) cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    chk("pre_abort_mem_addr", int'(mem_addr), 8);
    chk("pre_abort_dump_valid", int'(dump_valid), 1);
    v0 = 1'b1; v1 = 1'b1;
    rst_n = 1'b0;
    #1 check_reset_vals("abort");
    release_and_clear();

    // Icode 5 issued twice after a fresh clear, then read out.
    cycle(1'b1, 1'b0, 4'd5, 4'd0, 1'b0);
    cycle(1'b1, 1'b0, 4'd5, 4'd0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    beats = 0;
    for (int k = 1; k <= DR + N + 1; k++) begin
      cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      if (s_dv) begin
        beats++;
        chk("count_readout", int'(s_ddata), (s_daddr == 4'd5) ? 2 : 0);
      end
    end
    chk("count_readout_beats", beats, N);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/icode_count_ctrl.md
ICODE_COUNT_CTRL -- requirements
Module: icode_count_ctrl

Interface
REQ-001 SHALL have parameter ICODESIZE, default 4, width of an instruction code.
REQ-002 SHALL have parameter COUNTBITS, default 4, width of one count entry.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 4, counter-pipeline depth drained before readout.
REQ-004 SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports req0_valid/req1_valid  in  1  requester has an icode.
REQ-007 SHALL have ports req0_icode/req1_icode  in  ICODESIZE  requester icode.
REQ-008 SHALL have ports req0_ready/req1_ready  out  1  icode accepted this cycle.
REQ-009 SHALL have port dump_req  in  1  request table readout.
REQ-010 SHALL have port busy  out  1  high in every state except RUN.
REQ-011 SHALL have ports iss_valid out 1, iss_icode out ICODESIZE: issue stream to counter datapath.
REQ-012 SHALL have ports mem_addr out ICODESIZE, mem_we out 1, mem_wdata out COUNTBITS, mem_rdata in COUNTBITS: count-table port, 1-cycle synchronous read.
REQ-013 SHALL have ports dump_valid out 1, dump_addr out ICODESIZE, dump_data out COUNTBITS, dump_done out 1.

Function
REQ-014 SHALL implement FSM states CLEAR, RUN, DRAIN, DUMP.
REQ-015 CLEAR SHALL drive mem_we=1, mem_wdata=0, mem_addr=0..2^ICODESIZE-1 one per cycle, then enter RUN after the last address.
REQ-016 In RUN, grant SHALL be combinational: exactly one reqN_ready high when at least one reqN_valid high, none otherwise.
REQ-017 Arbitration SHALL be round-robin: pointer resets to req0; on contention the pointed requester wins; after any grant pointer moves to the other requester.
REQ-018 A lone valid requester SHALL be granted every cycle regardless of pointer.
REQ-019 Granted icode SHALL appear on iss_icode with iss_valid=1 exactly one cycle after the grant cycle; otherwise iss_valid=0, iss_icode=0.
REQ-020 dump_req high in RUN SHALL suppress all grants that cycle and move to DRAIN next cycle; dump_req outside RUN SHALL be ignored.
REQ-021 DRAIN SHALL last DRAIN_CYCLES cycles after the final iss_valid, no grants, then enter DUMP.
REQ-022 DUMP SHALL drive mem_we=0, mem_addr=0..2^ICODESIZE-1 one per cycle; one cycle after each address, dump_valid=1, dump_addr=that address, dump_data=mem_rdata.
REQ-023 dump_done SHALL pulse one cycle coincident with the last dump_valid; FSM SHALL return to RUN the following cycle.
REQ-024 reqN_ready SHALL be 0 in CLEAR, DRAIN, DUMP; requesters hold valid/icode until ready.
REQ-025 mem_we SHALL be 0 outside CLEAR; mem_wdata SHALL be 0 always.
REQ-026 Address counters SHALL wrap to 0 after 2^ICODESIZE-1 with no extra cycle.

Reset
REQ-027 reset low SHALL immediately force state CLEAR, address counter 0, pointer req0, iss_valid=0, iss_icode=0, dump_valid=0, dump_addr=0, dump_data=0, dump_done=0, busy=1, all ready=0.
REQ-028 Reset asserted mid-DRAIN or mid-DUMP SHALL abandon the operation; after release a full CLEAR runs.

Verification
REQ-029 Release reset -> 16 cycles mem_we=1 addr 0..15 wdata 0, then busy=0, RUN.
REQ-030 RUN, req0_valid=req1_valid=1 constant, icodes 3 and 7 -> ready alternates 0,1,0,1; iss_icode 3,7,3,7 one cycle later.
REQ-031 Only req1_valid=1 for 3 cycles -> req1_ready=1 each cycle, iss_valid=1 for 3 consecutive cycles.
REQ-032 dump_req pulse while both valid -> no ready that cycle, 4 idle cycles, 16 dump_valid beats addr 0..15, dump_done on addr 15, RUN next cycle.
REQ-033 Issue icode 5 twice, then dump -> dump beat addr 5 carries mem_rdata model value 2, others 0.
REQ-034 Reset low at DUMP address 8 -> all outputs reset values at once, CLEAR restarts at address 0 after release.
